// File: rtl/deser_pkg.sv
// Shared constants and the length-code mapping used by both ends of the serial link.
package deser_pkg;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_MIN_LEN = 3;
  localparam int unsigned DEF_MOD_W   = $clog2(DEF_DATA_W);

  // A full-width frame is encoded as 0; shorter frames carry their bit count.
  function automatic int unsigned len_to_mod(input int unsigned len,
                                             input int unsigned data_w = DEF_DATA_W);
    return (len >= data_w) ? 0 : len;
  endfunction

endpackage

// File: rtl/deserializer.sv
// Rebuilds MSB-first serial frames into parallel words with a length code;
// frames shorter than MIN_LEN are dropped and flagged.
module deserializer
  import deser_pkg::*;
#(
  parameter  int unsigned DATA_W  = DEF_DATA_W,
  parameter  int unsigned MIN_LEN = DEF_MIN_LEN,
  localparam int unsigned MOD_W   = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  input  logic              ser_last_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_mod_o,
  output logic              deser_data_val_o,
  output logic              deser_err_o,
  output logic              busy_o
);

  logic [MOD_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] cap_reg, cap_next;
  logic [DATA_W-1:0] cap_written;
  logic [DATA_W-1:0] bit_sel;
  logic [MOD_W:0]    frame_len;
  logic              close, emit, drop;

  logic [DATA_W-1:0] data_reg, data_next;
  logic [MOD_W-1:0]  mod_reg, mod_next;
  logic              val_reg, err_reg, busy_reg;

  // One-hot write position: bit cnt of the frame lands at index DATA_W-1-cnt.
  genvar gi;
  for (gi = 0; gi < DATA_W; gi++) begin : g_sel
    assign bit_sel[gi] = (cnt_reg == MOD_W'(DATA_W - 1 - gi));
  end

  always_comb begin
    cap_written = cap_reg;
    cnt_next    = cnt_reg;
    cap_next    = cap_reg;
    if (ser_data_val_i) begin
      cap_written = (cap_reg & ~bit_sel) | (bit_sel & {DATA_W{ser_data_i}});
    end
    frame_len = {1'b0, cnt_reg} + (MOD_W + 1)'(ser_data_val_i);
    close     = (frame_len == (MOD_W + 1)'(DATA_W)) ||
                (ser_last_i && (frame_len != '0));
    emit      = close && (frame_len >= (MOD_W + 1)'(MIN_LEN));
    drop      = close && !emit;
    // Clearing on close keeps stale bits out of the next, possibly shorter, frame.
    if (close) begin
      cnt_next = '0;
      cap_next = '0;
    end else begin
      cnt_next = frame_len[MOD_W-1:0];
      cap_next = cap_written;
    end
    data_next = data_reg;
    mod_next  = mod_reg;
    if (emit) begin
      data_next = cap_written;
      mod_next  = MOD_W'(len_to_mod(32'(frame_len), DATA_W));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_reg  <= '0;
      cap_reg  <= '0;
      data_reg <= '0;
      mod_reg  <= '0;
      val_reg  <= 1'b0;
      err_reg  <= 1'b0;
      busy_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      cap_reg  <= cap_next;
      data_reg <= data_next;
      mod_reg  <= mod_next;
      val_reg  <= emit;
      err_reg  <= drop;
      busy_reg <= (cnt_next != '0);
    end
  end

  assign deser_data_o     = data_reg;
  assign deser_mod_o      = mod_reg;
  assign deser_data_val_o = val_reg;
  assign deser_err_o      = err_reg;
  assign busy_o           = busy_reg;

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: bit-queue reference model checked every cycle plus directed frames.
module tb_deserializer;

  localparam int DATA_W  = 16;
  localparam int MIN_LEN = 3;
  localparam int MOD_W   = 4;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              ser_data_i = 1'b0;
  logic              ser_data_val_i = 1'b0;
  logic              ser_last_i = 1'b0;
  logic [DATA_W-1:0] deser_data_o;
  logic [MOD_W-1:0]  deser_mod_o;
  logic              deser_data_val_o;
  logic              deser_err_o;
  logic              busy_o;

  deserializer #(.DATA_W(DATA_W), .MIN_LEN(MIN_LEN)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .ser_data_i       (ser_data_i),
    .ser_data_val_i   (ser_data_val_i),
    .ser_last_i       (ser_last_i),
    .deser_data_o     (deser_data_o),
    .deser_mod_o      (deser_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .deser_err_o      (deser_err_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit                bits_q[$];
  logic [DATA_W-1:0] exp_data = '0;
  logic [MOD_W-1:0]  exp_mod = '0;
  logic              exp_val = 1'b0;
  logic              exp_err = 1'b0;
  logic              exp_busy = 1'b0;

  // observations of DUT pulses for directed checks
  int                val_pulses;
  int                err_pulses;
  logic [DATA_W-1:0] got_word;
  logic [MOD_W-1:0]  got_mod;
  logic [DATA_W-1:0] words_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_obs();
    val_pulses = 0;
    err_pulses = 0;
    words_q.delete();
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input logic d, input logic v, input logic l);
    int len;
    logic [DATA_W-1:0] word;
    ser_data_i     = d;
    ser_data_val_i = v;
    ser_last_i     = l;
    @(posedge clk_i);
    #1;
    exp_val = 1'b0;
    exp_err = 1'b0;
    if (v) bits_q.push_back(d);
    len = bits_q.size();
    if (len == DATA_W || (l && len > 0)) begin
      if (len >= MIN_LEN) begin
        word = '0;
        for (int i = 0; i < len; i++) word[DATA_W-1-i] = bits_q[i];
        exp_data = word;
        exp_mod  = MOD_W'(len % DATA_W);
        exp_val  = 1'b1;
      end else begin
        exp_err = 1'b1;
      end
      bits_q.delete();
    end
    exp_busy = (bits_q.size() != 0);
    check("val",  32'(deser_data_val_o), 32'(exp_val));
    check("err",  32'(deser_err_o),      32'(exp_err));
    check("data", 32'(deser_data_o),     32'(exp_data));
    check("mod",  32'(deser_mod_o),      32'(exp_mod));
    check("busy", 32'(busy_o),           32'(exp_busy));
    if (deser_data_val_o) begin
      val_pulses++;
      got_word = deser_data_o;
      got_mod  = deser_mod_o;
      words_q.push_back(deser_data_o);
    end
    if (deser_err_o) err_pulses++;
    $display("cyc d=%0b v=%0b l=%0b -> val=%0b err=%0b data=%04h mod=%0d busy=%0b",
             d, v, l, deser_data_val_o, deser_err_o, deser_data_o, deser_mod_o, busy_o);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 32'(deser_data_o), 32'h0);
    check({tag, "_mod"},  32'(deser_mod_o),  32'h0);
    check({tag, "_val"},  32'(deser_data_val_o), 32'h0);
    check({tag, "_err"},  32'(deser_err_o),  32'h0);
    check({tag, "_busy"}, 32'(busy_o),       32'h0);
  endtask

  // Asynchronous reset asserted between edges, held across one rising edge.
  task automatic do_reset();
    ser_data_val_i = 1'b0;
    ser_last_i     = 1'b0;
    #2;
    rst_n_i = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(posedge clk_i);
    #1;
    check_all_zero("rst_hold");
    rst_n_i = 1'b1;
    bits_q.delete();
    exp_data = '0;
    exp_mod  = '0;
    exp_val  = 1'b0;
    exp_err  = 1'b0;
    exp_busy = 1'b0;
    $display("reset applied");
  endtask

  task automatic send_bits(input logic [DATA_W-1:0] w, input int n,
                           input bit last_on_bit, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) step(1'b0, 1'b0, 1'b0);
      step(w[DATA_W-1-i], 1'b1, last_on_bit && (i == n - 1));
    end
  endtask

  initial begin
    int mod;
    int len;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] mask;

    do_reset();
    step(1'b0, 1'b0, 1'b0);

    // full word, no gaps
    clear_obs();
    send_bits(16'hA5C3, 16, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("full_pulses", 32'(val_pulses), 32'd1);
    check("full_word",   32'(got_word),   32'hA5C3);
    check("full_mod",    32'(got_mod),    32'd0);

    // 5-bit frame closed on its last bit
    clear_obs();
    send_bits(16'hB000, 5, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("short_word", 32'(got_word), 32'hB000);
    check("short_mod",  32'(got_mod),  32'd5);

    // detached last
    clear_obs();
    send_bits(16'hE000, 3, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("det_word", 32'(got_word), 32'hE000);
    check("det_mod",  32'(got_mod),  32'd3);

    // too short: error pulse, outputs hold
    clear_obs();
    send_bits(16'hC000, 2, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("tooshort_err", 32'(err_pulses),   32'd1);
    check("tooshort_val", 32'(val_pulses),   32'd0);
    check("tooshort_hold_data", 32'(deser_data_o), 32'hE000);
    check("tooshort_hold_mod",  32'(deser_mod_o),  32'd3);

    // lone last with nothing held: no pulse
    clear_obs();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("lone_last", 32'(val_pulses + err_pulses), 32'd0);

    // back-to-back with random gaps
    clear_obs();
    send_bits(16'h1234, 16, 1'b0, 1'b1);
    send_bits(16'hFFFF, 16, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("b2b_pulses", 32'(val_pulses), 32'd2);
    if (words_q.size() == 2) begin
      check("b2b_word0", 32'(words_q[0]), 32'h1234);
      check("b2b_word1", 32'(words_q[1]), 32'hFFFF);
    end

    // reset mid-frame
    clear_obs();
    send_bits(16'hABCD, 7, 1'b0, 1'b0);
    do_reset();
    send_bits(16'h00FF, 16, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("rstmid_pulses", 32'(val_pulses), 32'd1);
    check("rstmid_word",   32'(got_word),   32'h00FF);

    // loopback from a serializer-style source
    for (int t = 0; t < 40; t++) begin
      data = 16'($urandom);
      mod  = $urandom_range(2, 15);
      if (mod == 2) mod = 0;
      len  = (mod == 0) ? DATA_W : mod;
      mask = '0;
      for (int i = 0; i < len; i++) mask[DATA_W-1-i] = 1'b1;
      clear_obs();
      send_bits(data, len, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      check("loop_pulses", 32'(val_pulses), 32'd1);
      check("loop_word",   32'(got_word),   32'(data & mask));
      check("loop_mod",    32'(got_mod),    32'(mod));
    end

    // random soak including occasional resets
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(1'($urandom), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
